uncached_bus_bridge: RTL and testbench
======================================

// Module: uncached_bus_bridge
// PURPOSE
//   Upstream feeder for one input of the cache-bus arbiter. Converts a single
//   uncached CPU data access (MMIO, uncached segment) into a single-beat
//   cbus_req_t transaction and returns the read data or write completion.
//   One request outstanding at a time; optional write posting hides
//   store latency from the pipeline.
// PARAMETERS
//   POST_WRITES  1  1: writes get data_ok one cycle after acceptance; 0: after bus last
// PORTS
//   clk            in   1    clock, all state on posedge
//   reset          in   1    asynchronous, active-high reset
//   creq_valid     in   1    CPU request valid; held until creq_addr_ok
//   creq_is_write  in   1    1 = store, 0 = load
//   creq_addr      in   32   physical byte address
//   creq_size      in   3    access size, cbus size encoding (1/2/4 bytes)
//   creq_strobe    in   4    byte enables (writes); ignored for reads
//   creq_wdata     in   32   store data, already lane-aligned
//   creq_addr_ok   out  1    request accepted this cycle
//   cresp_data_ok  out  1    one-cycle completion pulse
//   cresp_rdata    out  32   load data, valid while cresp_data_ok=1 (raw bus word)
//   oreq           out  cbus_req_t   to arbiter input
//   oresp          in   cbus_resp_t  from arbiter
// BEHAVIOUR
//   Interface decided: single clock clk; reset is asynchronous, active-high.
//   Reset: state=IDLE; creq_addr_ok=0, cresp_data_ok=0, cresp_rdata=0, oreq='0;
//     reset mid-transaction drops oreq.valid immediately, no completion issued.
//   States: IDLE, REQ, RESP.
//   IDLE: creq_addr_ok = creq_valid (combinational). On accept at cycle T latch
//     is_write/addr/size/strobe/wdata; -> REQ. No other output asserted.
//   REQ: oreq.valid=1, fields from latch; len=0 (1 beat), burst=FIXED,
//     strobe=0 for reads. oreq held stable until oresp.ready&&oresp.last.
//     creq_addr_ok=0 throughout REQ.
//   Completion at cycle N (oresp.ready && oresp.last in REQ):
//     read: capture oresp.data; -> RESP; cresp_data_ok=1, cresp_rdata=data at N+1.
//     write, POST_WRITES=0: -> RESP; cresp_data_ok=1 at N+1, rdata unchanged.
//     write, POST_WRITES=1: -> IDLE at N+1 (new request acceptable at N+1).
//   Posted write: cresp_data_ok=1 at T+1 (first REQ cycle), exactly one pulse.
//   RESP: one cycle, then -> IDLE; creq_addr_ok=0 in RESP.
//   oresp.ready without last in REQ: ignored (single-beat; no data capture).
//   oresp ignored in IDLE/RESP. cresp_rdata holds last captured value otherwise.
//   Min read latency: accept T, oreq.valid T+1, data_ok >= T+2 plus bus wait.
//   No back-to-back overlap: next accept no earlier than cycle after RESP
//     (or N+1 for posted writes).
// TESTING
//   Read 0x1FD0_0000 size4, bus ready+last 3 cycles after oreq.valid with
//     data 0xDEAD_BEEF -> addr_ok at T, oreq.valid T+1..T+3, data_ok+rdata=0xDEADBEEF at T+4.
//   Write 0x1FD0_0004 strobe 4'b0011 data 0x1234, POST_WRITES=1 -> data_ok at T+1,
//     oreq strobe=4'b0011 held until last; second request stalls (addr_ok=0) until N+1.
//   Same write with POST_WRITES=0 -> data_ok exactly at N+1, single pulse.
//   Read with oresp.ready pulsed without last for 2 cycles then ready+last ->
//     only final beat data captured, oreq stable throughout.
//   Assert reset while in REQ -> oreq.valid=0 same cycle, no data_ok, state IDLE,
//     next read completes normally.
//   Back-to-back reads held valid -> second addr_ok only in cycle after RESP.

Source files
------------

// File: rtl/uncached_bus_bridge.sv
// Single-outstanding uncached CPU access to single-beat cache-bus transaction bridge.
// The bus request/response structs are flattened into oreq_*/oresp_* ports.
module uncached_bus_bridge #(
  parameter int unsigned POST_WRITES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        creq_valid,
  input  logic        creq_is_write,
  input  logic [31:0] creq_addr,
  input  logic [2:0]  creq_size,
  input  logic [3:0]  creq_strobe,
  input  logic [31:0] creq_wdata,
  output logic        creq_addr_ok,
  output logic        cresp_data_ok,
  output logic [31:0] cresp_rdata,
  output logic        oreq_valid,
  output logic        oreq_is_write,
  output logic [2:0]  oreq_size,
  output logic [31:0] oreq_addr,
  output logic [3:0]  oreq_strobe,
  output logic [31:0] oreq_data,
  output logic [3:0]  oreq_len,
  output logic [1:0]  oreq_burst,
  input  logic        oresp_ready,
  input  logic        oresp_last,
  input  logic [31:0] oresp_data
);

  localparam bit         POSTED      = (POST_WRITES != 0);
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  logic        is_write_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  strobe_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        first_q;
  logic        accept;
  logic        done;

  assign accept = (state_q == IDLE) && creq_valid;
  assign done   = (state_q == REQ) && oresp_ready && oresp_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (creq_valid) state_d = REQ;
      REQ:     if (done) state_d = (is_write_q && POSTED) ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      first_q    <= 1'b0;
    end else begin
      // first_q marks the first REQ cycle, where a posted write completes
      first_q <= accept;
      if (accept) begin
        is_write_q <= creq_is_write;
        addr_q     <= creq_addr;
        size_q     <= creq_size;
        strobe_q   <= creq_strobe;
        wdata_q    <= creq_wdata;
      end
      if (done && !is_write_q) rdata_q <= oresp_data;
    end
  end

  always_comb begin
    creq_addr_ok  = 1'b0;
    cresp_data_ok = 1'b0;
    oreq_valid    = 1'b0;
    oreq_is_write = 1'b0;
    oreq_size     = '0;
    oreq_addr     = '0;
    oreq_strobe   = '0;
    oreq_data     = '0;
    oreq_len      = '0;
    oreq_burst    = BURST_FIXED;
    case (state_q)
      IDLE: creq_addr_ok = creq_valid;
      REQ: begin
        oreq_valid    = 1'b1;
        oreq_is_write = is_write_q;
        oreq_size     = size_q;
        oreq_addr     = addr_q;
        oreq_strobe   = is_write_q ? strobe_q : '0;
        oreq_data     = wdata_q;
        cresp_data_ok = POSTED && is_write_q && first_q;
      end
      RESP:    cresp_data_ok = 1'b1;
      default: ;
    endcase
  end

  assign cresp_rdata = rdata_q;

endmodule

// File: tb/tb_uncached_bus_bridge.sv
// Directed bench for uncached_bus_bridge: posted (P) and non-posted (N) instances with completion scoreboards.
module tb_uncached_bus_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        cv_p, cv_n, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_size;
  logic [3:0]  c_strb;
  logic        rdy_p, rdy_n, r_last;
  logic [31:0] r_data;

  logic        aok_p, ok_p, v_p, we_p;
  logic [31:0] rd_p, a_p, d_p;
  logic [2:0]  sz_p;
  logic [3:0]  st_p, len_p;
  logic [1:0]  bu_p;
  logic        aok_n, ok_n, v_n, we_n;
  logic [31:0] rd_n, a_n, d_n;
  logic [2:0]  sz_n;
  logic [3:0]  st_n, len_n;
  logic [1:0]  bu_n;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } exp_t;
  exp_t q_p[$];
  exp_t q_n[$];
  exp_t e_p, e_n;

  always #5 clk = ~clk;

  uncached_bus_bridge #(.POST_WRITES(1)) dut_p (
    .clk(clk), .reset(reset),
    .creq_valid(cv_p), .creq_is_write(c_we), .creq_addr(c_addr), .creq_size(c_size),
    .creq_strobe(c_strb), .creq_wdata(c_wdata),
    .creq_addr_ok(aok_p), .cresp_data_ok(ok_p), .cresp_rdata(rd_p),
    .oreq_valid(v_p), .oreq_is_write(we_p), .oreq_size(sz_p), .oreq_addr(a_p),
    .oreq_strobe(st_p), .oreq_data(d_p), .oreq_len(len_p), .oreq_burst(bu_p),
    .oresp_ready(rdy_p), .oresp_last(r_last), .oresp_data(r_data)
  );

  uncached_bus_bridge #(.POST_WRITES(0)) dut_n (
    .clk(clk), .reset(reset),
    .creq_valid(cv_n), .creq_is_write(c_we), .creq_addr(c_addr), .creq_size(c_size),
    .creq_strobe(c_strb), .creq_wdata(c_wdata),
    .creq_addr_ok(aok_n), .cresp_data_ok(ok_n), .cresp_rdata(rd_n),
    .oreq_valid(v_n), .oreq_is_write(we_n), .oreq_size(sz_n), .oreq_addr(a_n),
    .oreq_strobe(st_n), .oreq_data(d_n), .oreq_len(len_n), .oreq_burst(bu_n),
    .oresp_ready(rdy_n), .oresp_last(r_last), .oresp_data(r_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_p(input logic is_read, input logic [31:0] data);
    exp_t e;
    e.is_read = is_read;
    e.data    = data;
    q_p.push_back(e);
  endtask

  task automatic push_n(input logic is_read, input logic [31:0] data);
    exp_t e;
    e.is_read = is_read;
    e.data    = data;
    q_n.push_back(e);
  endtask

  // Completion scoreboards: every data_ok pulse must match a pending request
  always @(negedge clk) begin
    if (ok_p) begin
      if (q_p.size() == 0) check("p_spurious_data_ok", {31'd0, ok_p}, 32'd0);
      else begin
        e_p = q_p.pop_front();
        if (e_p.is_read) check("p_sb_rdata", rd_p, e_p.data);
      end
    end
    if (ok_n) begin
      if (q_n.size() == 0) check("n_spurious_data_ok", {31'd0, ok_n}, 32'd0);
      else begin
        e_n = q_n.pop_front();
        if (e_n.is_read) check("n_sb_rdata", rd_n, e_n.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cv_p = 1'b0; cv_n = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    c_size = '0; c_strb = '0; rdy_p = 1'b0; rdy_n = 1'b0; r_last = 1'b0; r_data = '0;
    tick(); tick();
    check("rst_addr_ok", {31'd0, aok_p}, 32'd0);
    check("rst_data_ok", {31'd0, ok_p}, 32'd0);
    check("rst_rdata", rd_p, 32'd0);
    check("rst_oreq_valid_p", {31'd0, v_p}, 32'd0);
    check("rst_oreq_valid_n", {31'd0, v_n}, 32'd0);
    reset = 1'b0;
    tick();

    // Read 0x1FD00000: bus completes 3 cycles after oreq.valid
    cv_p = 1'b1; c_we = 1'b0; c_addr = 32'h1FD0_0000; c_size = 3'd2; c_strb = 4'hF;
    #1;
    check("rd_addr_ok_T", {31'd0, aok_p}, 32'd1);
    check("rd_oreq_valid_T", {31'd0, v_p}, 32'd0);
    push_p(1'b1, 32'hDEAD_BEEF);
    tick(); cv_p = 1'b0; #1;
    check("rd_oreq_valid_T1", {31'd0, v_p}, 32'd1);
    check("rd_oreq_addr", a_p, 32'h1FD0_0000);
    check("rd_oreq_size", {29'd0, sz_p}, 32'd2);
    check("rd_oreq_strobe", {28'd0, st_p}, 32'd0);
    check("rd_oreq_len", {28'd0, len_p}, 32'd0);
    check("rd_oreq_burst", {30'd0, bu_p}, 32'd0);
    check("rd_oreq_we", {31'd0, we_p}, 32'd0);
    check("rd_data_ok_T1", {31'd0, ok_p}, 32'd0);
    tick();
    check("rd_oreq_valid_T2", {31'd0, v_p}, 32'd1);
    check("rd_data_ok_T2", {31'd0, ok_p}, 32'd0);
    tick(); rdy_p = 1'b1; r_last = 1'b1; r_data = 32'hDEAD_BEEF; #1;
    check("rd_oreq_valid_T3", {31'd0, v_p}, 32'd1);
    check("rd_data_ok_T3", {31'd0, ok_p}, 32'd0);
    tick(); rdy_p = 1'b0; r_last = 1'b0; r_data = '0; #1;
    check("rd_data_ok_T4", {31'd0, ok_p}, 32'd1);
    check("rd_rdata_T4", rd_p, 32'hDEAD_BEEF);
    check("rd_oreq_valid_T4", {31'd0, v_p}, 32'd0);
    tick();
    check("rd_data_ok_T5", {31'd0, ok_p}, 32'd0);
    check("rd_rdata_hold", rd_p, 32'hDEAD_BEEF);

    // Posted write, second request (read) stalls until N+1
    cv_p = 1'b1; c_we = 1'b1; c_addr = 32'h1FD0_0004; c_size = 3'd1; c_strb = 4'b0011;
    c_wdata = 32'h0000_1234; #1;
    check("pw_addr_ok_T", {31'd0, aok_p}, 32'd1);
    push_p(1'b0, 32'd0);
    tick(); c_we = 1'b0; c_addr = 32'h1FD0_0010; c_size = 3'd2; c_strb = 4'hF; c_wdata = '0; #1;
    check("pw_data_ok_T1", {31'd0, ok_p}, 32'd1);
    check("pw_addr_ok_T1", {31'd0, aok_p}, 32'd0);
    check("pw_oreq_we", {31'd0, we_p}, 32'd1);
    check("pw_oreq_strobe_T1", {28'd0, st_p}, 32'h3);
    check("pw_oreq_data", d_p, 32'h0000_1234);
    check("pw_oreq_addr", a_p, 32'h1FD0_0004);
    tick();
    check("pw_data_ok_T2", {31'd0, ok_p}, 32'd0);
    check("pw_addr_ok_T2", {31'd0, aok_p}, 32'd0);
    check("pw_oreq_strobe_T2", {28'd0, st_p}, 32'h3);
    tick(); rdy_p = 1'b1; r_last = 1'b1; #1;
    check("pw_addr_ok_N", {31'd0, aok_p}, 32'd0);
    check("pw_oreq_valid_N", {31'd0, v_p}, 32'd1);
    tick(); rdy_p = 1'b0; r_last = 1'b0; #1;
    check("pw_oreq_valid_N1", {31'd0, v_p}, 32'd0);
    check("pw_addr_ok_N1", {31'd0, aok_p}, 32'd1);
    check("pw_data_ok_N1", {31'd0, ok_p}, 32'd0);
    push_p(1'b1, 32'hA5A5_0001);

    // Read with ready-without-last beats: only the final beat is captured
    tick(); cv_p = 1'b0; rdy_p = 1'b1; r_last = 1'b0; r_data = 32'hBAD0_0001; #1;
    check("rl_oreq_addr_0", a_p, 32'h1FD0_0010);
    check("rl_oreq_strobe", {28'd0, st_p}, 32'd0);
    tick(); r_data = 32'hBAD0_0002; #1;
    check("rl_oreq_valid_1", {31'd0, v_p}, 32'd1);
    check("rl_oreq_addr_1", a_p, 32'h1FD0_0010);
    check("rl_data_ok_1", {31'd0, ok_p}, 32'd0);
    tick(); r_last = 1'b1; r_data = 32'hA5A5_0001; #1;
    check("rl_oreq_valid_2", {31'd0, v_p}, 32'd1);
    check("rl_oreq_addr_2", a_p, 32'h1FD0_0010);
    check("rl_data_ok_2", {31'd0, ok_p}, 32'd0);
    tick(); rdy_p = 1'b0; r_last = 1'b0; r_data = '0; #1;
    check("rl_data_ok", {31'd0, ok_p}, 32'd1);
    check("rl_rdata", rd_p, 32'hA5A5_0001);
    tick();

    // Non-posted write on the POST_WRITES=0 instance
    cv_n = 1'b1; c_we = 1'b1; c_addr = 32'h1FD0_0004; c_size = 3'd1; c_strb = 4'b0011;
    c_wdata = 32'h0000_1234; #1;
    check("nw_addr_ok_T", {31'd0, aok_n}, 32'd1);
    push_n(1'b0, 32'd0);
    tick(); cv_n = 1'b0; #1;
    check("nw_data_ok_T1", {31'd0, ok_n}, 32'd0);
    check("nw_oreq_strobe", {28'd0, st_n}, 32'h3);
    check("nw_oreq_valid", {31'd0, v_n}, 32'd1);
    tick(); rdy_n = 1'b1; r_last = 1'b1; #1;
    check("nw_data_ok_N", {31'd0, ok_n}, 32'd0);
    tick(); rdy_n = 1'b0; r_last = 1'b0; #1;
    check("nw_data_ok_N1", {31'd0, ok_n}, 32'd1);
    check("nw_rdata_unchanged", rd_n, 32'd0);
    check("nw_addr_ok_resp", {31'd0, aok_n}, 32'd0);
    tick();
    check("nw_data_ok_N2", {31'd0, ok_n}, 32'd0);

    // Reset while in REQ drops oreq.valid at once, no completion
    cv_p = 1'b1; c_we = 1'b0; c_addr = 32'h1FD0_0020; c_size = 3'd2; c_strb = 4'hF; #1;
    check("rr_addr_ok_T", {31'd0, aok_p}, 32'd1);
    tick(); cv_p = 1'b0; #1;
    check("rr_oreq_valid_pre", {31'd0, v_p}, 32'd1);
    reset = 1'b1; #1;
    check("rr_oreq_valid_async", {31'd0, v_p}, 32'd0);
    check("rr_data_ok", {31'd0, ok_p}, 32'd0);
    check("rr_rdata_cleared", rd_p, 32'd0);
    tick(); reset = 1'b0;
    tick();
    check("rr_idle_valid", {31'd0, v_p}, 32'd0);
    check("rr_idle_data_ok", {31'd0, ok_p}, 32'd0);
    cv_p = 1'b1; c_addr = 32'h1FD0_0024; #1;
    check("rr_next_addr_ok", {31'd0, aok_p}, 32'd1);
    push_p(1'b1, 32'h0BAD_F00D);
    tick(); cv_p = 1'b0; #1;
    check("rr_next_oreq_addr", a_p, 32'h1FD0_0024);
    tick(); rdy_p = 1'b1; r_last = 1'b1; r_data = 32'h0BAD_F00D;
    tick(); rdy_p = 1'b0; r_last = 1'b0; r_data = '0; #1;
    check("rr_next_data_ok", {31'd0, ok_p}, 32'd1);
    check("rr_next_rdata", rd_p, 32'h0BAD_F00D);
    tick();

    // Back-to-back reads with valid held high
    cv_p = 1'b1; c_addr = 32'h1FD0_0030; #1;
    check("bb_addr_ok_1", {31'd0, aok_p}, 32'd1);
    push_p(1'b1, 32'h1111_1111);
    tick(); c_addr = 32'h1FD0_0034; rdy_p = 1'b1; r_last = 1'b1; r_data = 32'h1111_1111; #1;
    check("bb_addr_ok_req", {31'd0, aok_p}, 32'd0);
    tick(); rdy_p = 1'b0; r_last = 1'b0; r_data = '0; #1;
    check("bb_data_ok_1", {31'd0, ok_p}, 32'd1);
    check("bb_addr_ok_resp", {31'd0, aok_p}, 32'd0);
    tick();
    check("bb_addr_ok_2", {31'd0, aok_p}, 32'd1);
    push_p(1'b1, 32'h2222_2222);
    tick(); cv_p = 1'b0; rdy_p = 1'b1; r_last = 1'b1; r_data = 32'h2222_2222; #1;
    check("bb_oreq_addr_2", a_p, 32'h1FD0_0034);
    tick(); rdy_p = 1'b0; r_last = 1'b0; r_data = '0; #1;
    check("bb_data_ok_2", {31'd0, ok_p}, 32'd1);
    check("bb_rdata_2", rd_p, 32'h2222_2222);
    tick(); tick();

    check("sb_p_drained", q_p.size(), 32'd0);
    check("sb_n_drained", q_n.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
